// File: rtl/mc_mem_port.sv
// mc_mem_port: shared instruction/data memory port for the multicycle core.
// A request is accepted in IDLE, held for WAIT_STATES cycles, then completes
// with a one-cycle ready_o pulse in RESP. busy_o stalls the controller FSM
// while an access is outstanding. Out-of-range word indices complete with
// err_o=1: reads return 0 and writes are dropped.
// Optional build macro: MC_MEM_MISALIGN_TRAP_EN. When it is defined, a
// non-word-aligned address also raises err_o and is suppressed. When it is
// undefined, adr_i[1:0] is ignored.
module mc_mem_port #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wd_q;
  logic            err_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            adr_oob;
  logic            adr_misalign;
  logic            adr_err;
  logic            go_resp;
  logic [AW-1:0]   acc_idx;
  logic            acc_we;
  logic            acc_err;
  logic            mem_we;

  // A word index past the end of the array is an error, regardless of alignment.
  assign adr_oob = {2'b00, adr_i[31:2]} >= DEPTH_LIM;

`ifdef MC_MEM_MISALIGN_TRAP_EN
  assign adr_misalign = |adr_i[1:0];
`else
  // Byte offset is ignored. The accesses are word-aligned to adr_i[31:2].
  logic unused_adr_low;
  assign unused_adr_low = ^adr_i[1:0];
  assign adr_misalign   = 1'b0;
`endif

  assign adr_err = adr_oob | adr_misalign;

  // Pick the access attributes used on the edge that enters RESP. With zero
  // wait states, that edge is the accept edge, so the live inputs are used.
  always_comb begin
    go_resp = 1'b0;
    acc_idx = idx_q;
    acc_we  = we_q;
    acc_err = err_q;
    if (state == IDLE) begin
      acc_idx = adr_i[AW+1:2];
      acc_we  = we_i;
      acc_err = adr_err;
      go_resp = req_i && (WAIT_STATES == 0);
    end else if (state == WAIT) begin
      go_resp = (cnt == 4'd1);
    end
  end

  // Writes commit on the edge that ends RESP. A reset on that edge cancels the write.
  assign mem_we = (state == RESP) && we_q && !err_q && !reset;

  // Memory array write port. The contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wd_q;
    end
  end

  // Control FSM. All outputs are registered, and read data is captured as RESP is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wd_q    <= 32'd0;
      err_q   <= 1'b0;
      rd_o    <= 32'd0;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ready_o <= go_resp;
      err_o   <= go_resp & acc_err;
      if (go_resp && !acc_we) begin
        rd_o <= acc_err ? 32'd0 : mem[acc_idx];
      end
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q   <= we_i;
            idx_q  <= adr_i[AW+1:2];
            wd_q   <= wd_i;
            err_q  <= adr_err;
            cnt    <= WAIT_INIT;
            busy_o <= 1'b1;
            state  <= (WAIT_STATES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          cnt    <= 4'd0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mc_mem_port.md
Name: mc_mem_port

Overview:
Shared instruction/data memory port for the multicycle RISC-V core. It sits directly upstream of the controller: fetch reads here feed the instruction register, whose op/funct3/funct7 fields drive the main FSM. It also services lw/sw accesses at the address selected by AdrSrc. A req/ready handshake with configurable wait states lets the core freeze its FSM while an access is in flight.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; word index = adr_i[31:2].
WAIT_STATES, 2, extra cycles between accept and ready_o (0..15).

Ports:
clk  input  1  clock.
reset  input  1  reset, synchronous, active-high.
req_i  input  1  access request; requester holds high until ready_o, then drops it.
we_i  input  1  1 = write (sw), 0 = read (fetch/lw); sampled at accept.
adr_i  input  32  byte address; sampled at accept.
wd_i  input  32  write data; sampled at accept.
rd_o  output  32  read data; valid on the ready_o cycle, held until the next read completes.
ready_o  output  1  one-cycle completion pulse.
busy_o  output  1  high while an access is outstanding (stall for controller FSM).
err_o  output  1  error flag for the completing access; valid with ready_o.

Behaviour:
- Reset: state=IDLE, rd_o=0, ready_o=0, busy_o=0, err_o=0, wait counter=0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE, req_i=1 (accept):
  - latch we_i, adr_i, wd_i;
  - load counter with WAIT_STATES;
  - go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: decrement counter each cycle. When counter reaches 1, next state is RESP, giving exactly WAIT_STATES cycles in WAIT.
- RESP (one cycle): ready_o=1.
  - Read: rd_o = mem[latched index].
  - Write: mem[latched index] <= latched wd, committed on this clock edge.
  - Next state: IDLE, always.
- Latency: ready_o asserts WAIT_STATES+1 cycles after the accept edge. Minimum accept-to-accept spacing is WAIT_STATES+2 cycles.
- busy_o = (state != IDLE), registered. It is high the cycle after accept, through RESP inclusive.
- req_i, we_i, adr_i, wd_i changes during WAIT/RESP are ignored (latched values are used). A req_i still high in IDLE after RESP starts a new access.
- Out-of-range (word index >= DEPTH_WORDS):
  - read: rd_o=0, err_o=1;
  - write: dropped, err_o=1;
  - ready_o still pulses, so the core never hangs.
- err_o is 0 on the ready cycle of every in-range access, and 0 whenever ready_o=0.
- Reset mid-operation (WAIT or RESP): return to IDLE next edge, no write commit, no ready_o pulse, rd_o cleared to 0.
- Read-after-write to the same word in back-to-back accesses returns the new data.
- rd_o is unchanged by write completions.

Optional Feature:
MC_MEM_MISALIGN_TRAP_EN
- Defined: an access with adr_i[1:0]!=0 completes normally in timing (ready_o after WAIT_STATES+1) with err_o=1.
  - Write: suppressed.
  - Read: rd_o=0.
  - Out-of-range checks still apply; err_o is the OR of both conditions.
- Undefined: adr_i[1:0] is ignored (word-aligned access to adr_i[31:2]); only out-of-range raises err_o.

Test Plan:
1. Reset held 2 cycles, then released with req_i=0 -> rd_o=0, ready_o=0, busy_o=0, err_o=0 for 5 cycles.
2. WAIT_STATES=2: write 0xDEADBEEF to 0x10, then read 0x10 -> each ready_o exactly 3 cycles after its accept; read rd_o=0xDEADBEEF, err_o=0; busy_o high 3 cycles per access.
3. WAIT_STATES=0: back-to-back reads of 0x0 then 0x4 with req_i held high -> ready_o every 2nd cycle; rd_o matches preloaded words in order.
4. Read at 0x400 (index 256, DEPTH 256) -> ready_o after 3 cycles, rd_o=0, err_o=1. A following write to 0x400 leaves word 0 unchanged.
5. Accept a write to 0x20 (0x12345678), assert reset during WAIT -> no ready_o; a later read of 0x20 returns the old value; busy_o=0 after reset.
6. Read at 0x13 -> with MC_MEM_MISALIGN_TRAP_EN: err_o=1, rd_o=0. Without it: rd_o=mem[4], err_o=0.
